// File: rtl/asm_count_pkg.sv
// Shared types for the ASM counting system.
//   state_t : control FSM encoding (S_IDLE, S_COUNT, S_DONE)
package asm_count_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/asm_count_ctrl.sv
// Control FSM of the ASM counting system. Decides, from start/abort and the
// two qualifying bits of counter A, which datapath strobes fire each cycle.
// Ports:
//   clk, rst_b           clock, asynchronous active-low reset
//   start                begin a run (only honoured in S_IDLE)
//   a_e_bit, a_stop_bit  current A[E_BIT] and A[STOP_BIT]
//   abort                cancel a run (tied low by the top when not built in)
//   clr_a_f              clear A and F
//   incr_a               increment A
//   load_e               load E from A[E_BIT]
//   set_f                set F
//   incr_run             increment the completed-run counter
//   busy                 state != S_IDLE
//   done                 state == S_DONE
module asm_count_ctrl
  import asm_count_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  input  logic a_e_bit,
  input  logic a_stop_bit,
  input  logic abort,
  output logic clr_a_f,
  output logic incr_a,
  output logic load_e,
  output logic set_f,
  output logic incr_run,
  output logic busy,
  output logic done
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clr_a_f  = 1'b0;
    incr_a   = 1'b0;
    load_e   = 1'b0;
    set_f    = 1'b0;
    incr_run = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_a_f = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        // abort wins over the exit test and freezes A and E
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          incr_a = 1'b1;
          load_e = 1'b1;
          if (a_e_bit && a_stop_bit) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        // an abort here cancels the completion bookkeeping
        if (!abort) begin
          set_f    = 1'b1;
          incr_run = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: rtl/asm_count_sys.sv
// ASM counting system: control FSM plus datapath (counter A, flags E and F,
// completed-run counter). On start A and F clear, A counts up with E tracking
// A[E_BIT]; when A[E_BIT] and A[STOP_BIT] are both set the run ends, F is set
// and run_cnt advances.
// Optional feature: define ASM_ABORT_EN to add the abort input, which cancels
// a run in progress without setting F or counting the run.
// Ports:
//   clk      clock
//   rst_b    asynchronous active-low reset
//   start    begin a run (sampled in idle only)
//   abort    cancel the run (ASM_ABORT_EN builds only)
//   a        counter A (W bits)
//   e        flag E
//   f        flag F, run complete
//   busy     FSM not idle
//   done     one cycle per completed run
//   run_cnt  completed runs, wraps modulo 2^RUN_W
module asm_count_sys
  import asm_count_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned E_BIT    = 2,
  parameter int unsigned STOP_BIT = 3,
  parameter int unsigned RUN_W    = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
`ifdef ASM_ABORT_EN
  input  logic             abort,
`endif
  output logic [W-1:0]     a,
  output logic             e,
  output logic             f,
  output logic             busy,
  output logic             done,
  output logic [RUN_W-1:0] run_cnt
);

  if ((E_BIT >= W) || (STOP_BIT >= W) || (E_BIT == STOP_BIT) || (W < 2)) begin : g_bad_params
    $error("asm_count_sys: illegal W/E_BIT/STOP_BIT combination");
  end

  logic abort_i;
`ifdef ASM_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  logic             clr_a_f;
  logic             incr_a;
  logic             load_e;
  logic             set_f;
  logic             incr_run;

  logic [W-1:0]     a_q, a_d;
  logic             e_q, e_d;
  logic             f_q, f_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

  asm_count_ctrl u_ctrl (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .a_e_bit    (a_q[E_BIT]),
    .a_stop_bit (a_q[STOP_BIT]),
    .abort      (abort_i),
    .clr_a_f    (clr_a_f),
    .incr_a     (incr_a),
    .load_e     (load_e),
    .set_f      (set_f),
    .incr_run   (incr_run),
    .busy       (busy),
    .done       (done)
  );

  always_comb begin
    a_d       = a_q;
    e_d       = e_q;
    f_d       = f_q;
    run_cnt_d = run_cnt_q;
    if (clr_a_f) begin
      a_d = '0;
      f_d = 1'b0;
    end
    if (incr_a) begin
      a_d = a_q + {{(W-1){1'b0}}, 1'b1};
    end
    // E follows the pre-increment value of A
    if (load_e) begin
      e_d = a_q[E_BIT];
    end
    if (set_f) begin
      f_d = 1'b1;
    end
    if (incr_run) begin
      run_cnt_d = run_cnt_q + {{(RUN_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q       <= '0;
      e_q       <= 1'b0;
      f_q       <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      a_q       <= a_d;
      e_q       <= e_d;
      f_q       <= f_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign a       = a_q;
  assign e       = e_q;
  assign f       = f_q;
  assign run_cnt = run_cnt_q;

endmodule
